vga_sync_decoder: RTL and testbench

Receive-side counterpart of the VGA sync generator. It samples the hsync/vsync/blank_n strobes (active-high sync pulses, same clock domain) and recovers pixel coordinates. It also measures line and active-window timing and declares lock after consecutive conforming frames. Used on the capture/overlay path and as an in-system timing checker on the generator output.

---
 rtl/vga_sync_decoder.sv | 194 +++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: samples hsync/vsync/blank_n, recovers x/y coordinates,
// measures line/frame timing and declares lock after consecutive conforming frames.
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned TIMEOUT     = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_n_in,
  output logic        locked,
  output logic        pixel_valid,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        frame_start,
  output logic        frame_err,
  output logic [10:0] h_period,
  output logic [9:0]  last_width,
  output logic [8:0]  last_lines
);

  localparam logic [9:0]  H_ACT_C   = 10'(H_ACTIVE);
  localparam logic [8:0]  V_ACT_C   = 9'(V_ACTIVE);
  localparam logic [2:0]  LOCK_C    = 3'(LOCK_FRAMES);
  localparam logic [10:0] TIMEOUT_C = 11'(TIMEOUT);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  state_e      state_q, state_d;
  logic        s_h_q, s_v_q, s_b_q, p_h_q, p_v_q, p_b_q;
  logic [10:0] hcnt_q, hcnt_d;
  logic        h_seen_q, h_seen_d;
  logic [9:0]  run_q, run_d;
  logic [8:0]  lines_q, lines_d;
  logic        bad_q, bad_d;
  logic [2:0]  good_q, good_d;
  logic        pv_q, pv_d, fs_q, fs_d, fe_q, fe_d;
  logic [9:0]  x_q, x_d, lw_q, lw_d;
  logic [8:0]  y_q, y_d, ll_q, ll_d;
  logic [10:0] hper_q, hper_d;

  logic       h_rise, v_rise, b_rise, b_fall;
  logic [8:0] lines_inc;
  logic       frame_bad, frame_good, timeout;

  assign h_rise = s_h_q & ~p_h_q;
  assign v_rise = s_v_q & ~p_v_q;
  assign b_rise = s_b_q & ~p_b_q;
  assign b_fall = ~s_b_q & p_b_q;

  // A line ending in the same cycle as the vsync rise still belongs to the ending frame.
  assign lines_inc  = (b_fall && lines_q != '1) ? lines_q + 9'd1 : lines_q;
  assign frame_bad  = bad_q | (b_fall && run_q != H_ACT_C) | (s_b_q & (s_h_q | s_v_q));
  assign frame_good = (lines_inc == V_ACT_C) && !frame_bad;
  assign timeout    = hcnt_q >= TIMEOUT_C;

  always_comb begin
    hcnt_d   = hcnt_q;
    h_seen_d = h_seen_q;
    hper_d   = hper_q;
    if (h_rise) begin
      hcnt_d   = 11'd1;
      h_seen_d = 1'b1;
      if (h_seen_q) hper_d = hcnt_q;
    end else if (hcnt_q != '1) begin
      hcnt_d = hcnt_q + 11'd1;
    end

    run_d = run_q;
    if (b_rise)                   run_d = 10'd1;
    else if (s_b_q && run_q != '1) run_d = run_q + 10'd1;

    lw_d = b_fall ? run_q : lw_q;

    lines_d = lines_inc;
    bad_d   = frame_bad;
    fs_d    = v_rise;
    ll_d    = ll_q;
    if (v_rise) begin
      lines_d = '0;
      bad_d   = 1'b0;
      ll_d    = lines_inc;
    end

    state_d = state_q;
    good_d  = good_q;
    fe_d    = 1'b0;
    case (state_q)
      SEARCH: begin
        if (v_rise) begin
          state_d = MEASURE;
          good_d  = '0;
        end
      end
      MEASURE: begin
        if (timeout) begin
          state_d = SEARCH;
          good_d  = '0;
          fe_d    = 1'b1;
        end else if (v_rise) begin
          if (frame_good) begin
            good_d = good_q + 3'd1;
            if (good_q + 3'd1 == LOCK_C) state_d = LOCKED;
          end else begin
            good_d = '0;
            fe_d   = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (timeout || (v_rise && !frame_good)) begin
          state_d = SEARCH;
          good_d  = '0;
          fe_d    = 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase

    // Validity uses the current state, so a lock taken this cycle shows from the next pixel.
    pv_d = (state_q == LOCKED) && s_b_q;
    x_d  = x_q;
    y_d  = y_q;
    if (pv_d) begin
      x_d = b_rise ? 10'd0 : run_q;
      y_d = lines_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEARCH;
      s_h_q    <= 1'b0;
      s_v_q    <= 1'b0;
      s_b_q    <= 1'b0;
      p_h_q    <= 1'b0;
      p_v_q    <= 1'b0;
      p_b_q    <= 1'b0;
      hcnt_q   <= '0;
      h_seen_q <= 1'b0;
      run_q    <= '0;
      lines_q  <= '0;
      bad_q    <= 1'b0;
      good_q   <= '0;
      pv_q     <= 1'b0;
      fs_q     <= 1'b0;
      fe_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      lw_q     <= '0;
      ll_q     <= '0;
      hper_q   <= '0;
    end else begin
      state_q  <= state_d;
      s_h_q    <= hsync_in;
      s_v_q    <= vsync_in;
      s_b_q    <= blank_n_in;
      p_h_q    <= s_h_q;
      p_v_q    <= s_v_q;
      p_b_q    <= s_b_q;
      hcnt_q   <= hcnt_d;
      h_seen_q <= h_seen_d;
      run_q    <= run_d;
      lines_q  <= lines_d;
      bad_q    <= bad_d;
      good_q   <= good_d;
      pv_q     <= pv_d;
      fs_q     <= fs_d;
      fe_q     <= fe_d;
      x_q      <= x_d;
      y_q      <= y_d;
      lw_q     <= lw_d;
      ll_q     <= ll_d;
      hper_q   <= hper_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign pixel_valid = pv_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign frame_err   = fe_q;
  assign h_period    = hper_q;
  assign last_width  = lw_q;
  assign last_lines  = ll_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench: a miniature sync generator (8x4 active, 16x7 total) drives the decoder.
module tb_vga_sync_decoder;

  localparam int HA = 8;
  localparam int VA = 4;
  localparam int HT = 16;
  localparam int VT = 7;
  localparam int HS = 10;
  localparam int VS = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, blank_n_in = 1'b0;
  logic        locked, pixel_valid, frame_start, frame_err;
  logic [9:0]  x, last_width;
  logic [8:0]  y, last_lines;
  logic [10:0] h_period;

  int checks = 0;
  int errors = 0;
  int col = 0, line = 0;
  bit hold_h = 0, short_line_en = 0, short_frame_en = 0;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2), .TIMEOUT(40)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_n_in(blank_n_in),
    .locked(locked), .pixel_valid(pixel_valid), .x(x), .y(y),
    .frame_start(frame_start), .frame_err(frame_err), .h_period(h_period),
    .last_width(last_width), .last_lines(last_lines)
  );

  always #5 clk = ~clk;

  // Drive one generator position, then wait for the edge; outputs afterwards describe the
  // position driven one call earlier.
  task automatic step();
    hsync_in   = !hold_h && col >= HS && col < HS + 2;
    vsync_in   = (line == VS);
    blank_n_in = col < HA && line < (short_frame_en ? VA - 1 : VA)
                 && !(short_line_en && line == 2 && col == HA - 1);
    @(posedge clk); #1;
    col++;
    if (col == HT) begin
      col = 0;
      line++;
      if (line == VT) line = 0;
    end
  endtask

  task automatic goto(input int l, input int c);
    for (int n = 0; n <= HT * VT && !(line == l && col == c); n++) step();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({locked, pixel_valid, frame_start, frame_err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {locked, pixel_valid, frame_start, frame_err}); end
    checks++; if (x !== 10'd0 || y !== 9'd0) begin errors++; $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", x, y); end
    checks++; if (h_period !== 11'd0 || last_width !== 10'd0 || last_lines !== 9'd0) begin errors++; $display("FAIL reset_meas: got %0d %0d %0d expected 0 0 0", h_period, last_width, last_lines); end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    goto(VS, 0); step(); step();
    checks++; if (frame_start !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL lock_first_vs: got fs=%b lk=%b expected 1 0", frame_start, locked); end
    step();
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL lock_fs_pulse: got %b expected 0", frame_start); end
    goto(VS, 0); step(); step();
    checks++; if (locked !== 1'b0 || last_lines !== 9'd4) begin errors++; $display("FAIL lock_second_vs: got lk=%b lines=%0d expected 0 4", locked, last_lines); end
    goto(VS, 0); step();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b expected 0", locked); end
    step();
    checks++; if (locked !== 1'b1 || frame_err !== 1'b0) begin errors++; $display("FAIL lock_third_vs: got lk=%b fe=%b expected 1 0", locked, frame_err); end
    checks++; if (h_period !== 11'd16 || last_width !== 10'd8 || last_lines !== 9'd4) begin errors++; $display("FAIL lock_meas: got %0d %0d %0d expected 16 8 4", h_period, last_width, last_lines); end
  endtask

  task automatic test_coords();
    goto(0, 0); step();
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL coord_latency: got pv=%b expected 0", pixel_valid); end
    step();
    checks++; if (pixel_valid !== 1'b1 || x !== 10'd0 || y !== 9'd0) begin errors++; $display("FAIL coord_first: got pv=%b x=%0d y=%0d expected 1 0 0", pixel_valid, x, y); end
    goto(1, 3); step(); step();
    checks++; if (pixel_valid !== 1'b1 || x !== 10'd3 || y !== 9'd1) begin errors++; $display("FAIL coord_mid: got pv=%b x=%0d y=%0d expected 1 3 1", pixel_valid, x, y); end
    goto(3, 7); step(); step();
    checks++; if (pixel_valid !== 1'b1 || x !== 10'd7 || y !== 9'd3) begin errors++; $display("FAIL coord_last: got pv=%b x=%0d y=%0d expected 1 7 3", pixel_valid, x, y); end
    step();
    checks++; if (pixel_valid !== 1'b0 || x !== 10'd7 || y !== 9'd3) begin errors++; $display("FAIL coord_hold: got pv=%b x=%0d y=%0d expected 0 7 3", pixel_valid, x, y); end
  endtask

  task automatic test_short_line();
    goto(0, 0);
    short_line_en = 1;
    goto(3, 0);
    short_line_en = 0;
    checks++; if (last_width !== 10'd7) begin errors++; $display("FAIL short_width: got %0d expected 7", last_width); end
    goto(VS, 0); step();
    checks++; if (locked !== 1'b1 || frame_err !== 1'b0) begin errors++; $display("FAIL short_pre: got lk=%b fe=%b expected 1 0", locked, frame_err); end
    step();
    checks++; if (frame_err !== 1'b1 || locked !== 1'b0 || frame_start !== 1'b1) begin errors++; $display("FAIL short_err: got fe=%b lk=%b fs=%b expected 1 0 1", frame_err, locked, frame_start); end
    step();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL short_err_pulse: got %b expected 0", frame_err); end
    goto(VS, 0); step(); step();
    goto(VS, 0); step(); step();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL short_relock_early: got %b expected 0", locked); end
    goto(VS, 0); step(); step();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL short_relock: got %b expected 1", locked); end
  endtask

  task automatic test_timeout();
    int n_err;
    goto(0, 0);
    hold_h = 1;
    goto(2, 3);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL timeout_pre: got %b expected 1", locked); end
    step();
    checks++; if (locked !== 1'b0 || frame_err !== 1'b1) begin errors++; $display("FAIL timeout_hit: got lk=%b fe=%b expected 0 1", locked, frame_err); end
    hold_h = 0;
    n_err = 0;
    for (int n = 0; n <= HT * VT && !(line == VS && col == 0); n++) begin
      step();
      n_err += int'(frame_err);
    end
    checks++; if (n_err !== 0) begin errors++; $display("FAIL timeout_single: got %0d extra pulses expected 0", n_err); end
    step(); step();
    checks++; if (frame_start !== 1'b1 || frame_err !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL timeout_vs: got fs=%b fe=%b lk=%b expected 1 0 0", frame_start, frame_err, locked); end
  endtask

  task automatic test_short_frame();
    goto(VS, 0); step(); step();
    checks++; if (locked !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL sframe_good1: got lk=%b fe=%b expected 0 0", locked, frame_err); end
    short_frame_en = 1;
    goto(4, 0);
    short_frame_en = 0;
    goto(VS, 0); step(); step();
    checks++; if (frame_err !== 1'b1 || locked !== 1'b0 || last_lines !== 9'd3) begin errors++; $display("FAIL sframe_err: got fe=%b lk=%b lines=%0d expected 1 0 3", frame_err, locked, last_lines); end
    goto(VS, 0); step(); step();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sframe_relock_early: got %b expected 0", locked); end
    goto(VS, 0); step(); step();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sframe_relock: got %b expected 1", locked); end
  endtask

  task automatic test_reset_midframe();
    goto(1, 4);
    rst = 1'b1;
    #1;
    checks++; if ({locked, pixel_valid, frame_start, frame_err} !== 4'b0 || x !== 10'd0 || y !== 9'd0) begin errors++; $display("FAIL rstmid_flags: got %b x=%0d y=%0d expected 0000 0 0", {locked, pixel_valid, frame_start, frame_err}, x, y); end
    checks++; if (h_period !== 11'd0 || last_width !== 10'd0 || last_lines !== 9'd0) begin errors++; $display("FAIL rstmid_meas: got %0d %0d %0d expected 0 0 0", h_period, last_width, last_lines); end
    step(); step();
    rst = 1'b0;
    goto(VS, 0); step(); step();
    checks++; if (frame_start !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL rstmid_vs1: got fs=%b lk=%b expected 1 0", frame_start, locked); end
    goto(VS, 0); step(); step();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rstmid_vs2: got %b expected 0", locked); end
    goto(VS, 0); step(); step();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rstmid_vs3: got %b expected 1", locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_coords();
    test_short_line();
    test_timeout();
    test_short_frame();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
